// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache: 8 blocks x 4 bytes, tag[7:5] index[4:2] offset[1:0].
// Define CACHE_STATS_EN to build the saturating hit/miss counters; otherwise they read 0.
module dcache_ctrl (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [7:0]  address_i,
    input  logic [7:0]  writedata_i,
    output logic [7:0]  readdata_o,
    output logic        busywait_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [5:0]  mem_address_o,
    output logic [31:0] mem_writedata_o,
    input  logic [31:0] mem_readdata_i,
    input  logic        mem_busywait_i,
    output logic [15:0] hit_count_o,
    output logic [15:0] miss_count_o
);
    typedef enum logic [1:0] {StIdle, StWriteback, StFetch, StUpdate} state_e;

    state_e      state_q;
    logic [7:0]  valid_q;
    logic [7:0]  dirty_q;
    logic [2:0]  tag_q [8];
    logic [31:0] data_q [8];

    logic [2:0] tag;
    logic [2:0] index;
    logic [1:0] offset;
    logic       req;
    logic       hit;
    logic       write_hit;

    assign tag        = address_i[7:5];
    assign index      = address_i[4:2];
    assign offset     = address_i[1:0];
    assign req        = read_i | write_i;
    assign hit        = valid_q[index] && (tag_q[index] == tag);
    assign busywait_o = !reset_i && req && ((state_q != StIdle) || !hit);
    assign write_hit  = !reset_i && write_i && hit && (state_q == StIdle);

    always_comb begin
        readdata_o = '0;
        if (!reset_i && hit) begin
            readdata_o = data_q[index][{offset, 3'b000} +: 8];
        end
    end

    // Memory-side outputs are registered on entry to each state so they drop at reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q         <= StIdle;
            valid_q         <= '0;
            dirty_q         <= '0;
            mem_read_o      <= 1'b0;
            mem_write_o     <= 1'b0;
            mem_address_o   <= '0;
            mem_writedata_o <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req && !hit) begin
                        if (dirty_q[index]) begin
                            state_q         <= StWriteback;
                            mem_write_o     <= 1'b1;
                            mem_address_o   <= {tag_q[index], index};
                            mem_writedata_o <= data_q[index];
                        end else begin
                            state_q       <= StFetch;
                            mem_read_o    <= 1'b1;
                            mem_address_o <= address_i[7:2];
                        end
                    end else if (write_i) begin
                        dirty_q[index] <= 1'b1;
                    end
                end
                StWriteback: begin
                    if (!mem_busywait_i) begin
                        state_q         <= StFetch;
                        mem_write_o     <= 1'b0;
                        mem_read_o      <= 1'b1;
                        mem_address_o   <= address_i[7:2];
                        mem_writedata_o <= '0;
                    end
                end
                StFetch: begin
                    if (!mem_busywait_i) begin
                        state_q       <= StUpdate;
                        mem_read_o    <= 1'b0;
                        mem_address_o <= '0;
                    end
                end
                StUpdate: begin
                    valid_q[index] <= 1'b1;
                    dirty_q[index] <= 1'b0;
                    state_q        <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Tag and data arrays carry no reset; validity alone decides whether they are used.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (state_q == StUpdate) begin
                data_q[index] <= mem_readdata_i;
                tag_q[index]  <= tag;
            end else if (write_hit) begin
                data_q[index][{offset, 3'b000} +: 8] <= writedata_i;
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_q;
    logic [15:0] miss_q;
    logic        refill_done_q;

    // refill_done_q suppresses counting the hit that completes a refilled access.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hit_q         <= '0;
            miss_q        <= '0;
            refill_done_q <= 1'b0;
        end else begin
            if (state_q == StUpdate) begin
                refill_done_q <= 1'b1;
            end else if (state_q == StIdle) begin
                refill_done_q <= 1'b0;
            end
            if ((state_q == StIdle) && req && hit && !refill_done_q && (hit_q != 16'hFFFF)) begin
                hit_q <= hit_q + 16'd1;
            end
            if ((state_q == StIdle) && req && !hit && (miss_q != 16'hFFFF)) begin
                miss_q <= miss_q + 16'd1;
            end
        end
    end

    assign hit_count_o  = hit_q;
    assign miss_count_o = miss_q;
`else
    assign hit_count_o  = '0;
    assign miss_count_o = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: stimulus queues expected load data and memory requests,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_dcache_ctrl;
`ifdef CACHE_STATS_EN
    localparam bit Stats = 1'b1;
`else
    localparam bit Stats = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_i;
    logic        read_i;
    logic        write_i;
    logic [7:0]  address_i;
    logic [7:0]  writedata_i;
    logic [7:0]  readdata_o;
    logic        busywait_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [5:0]  mem_address_o;
    logic [31:0] mem_writedata_o;
    logic [31:0] mem_readdata_i;
    logic        mem_busywait_i;
    logic [15:0] hit_count_o;
    logic [15:0] miss_count_o;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } mem_txn_t;

    mem_txn_t   exp_mem[$];
    logic [7:0] exp_rd[$];

    int unsigned mem_lat = 0;
    int unsigned mem_cnt;
    logic [31:0] rd_q;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .read_i         (read_i),
        .write_i        (write_i),
        .address_i      (address_i),
        .writedata_i    (writedata_i),
        .readdata_o     (readdata_o),
        .busywait_o     (busywait_o),
        .mem_read_o     (mem_read_o),
        .mem_write_o    (mem_write_o),
        .mem_address_o  (mem_address_o),
        .mem_writedata_o(mem_writedata_o),
        .mem_readdata_i (mem_readdata_i),
        .mem_busywait_i (mem_busywait_i),
        .hit_count_o    (hit_count_o),
        .miss_count_o   (miss_count_o)
    );

    function automatic logic [31:0] mem_word(input logic [5:0] a);
        case (a)
            6'h09:   return 32'hDDCCBBAA;
            6'h29:   return 32'h11223344;
            6'h10:   return 32'hA1B2C3D4;
            default: return {4{2'b10, a}};
        endcase
    endfunction

    // Memory model: busy for mem_lat cycles, completes on the following posedge.
    assign mem_busywait_i = (mem_read_o || mem_write_o) && (mem_cnt < mem_lat);
    assign mem_readdata_i = mem_read_o ? mem_word(mem_address_o) : rd_q;

    always @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            mem_cnt <= 0;
        end else if (mem_read_o || mem_write_o) begin
            if (mem_cnt < mem_lat) begin
                mem_cnt <= mem_cnt + 1;
            end else begin
                mem_cnt <= 0;
                if (mem_read_o) rd_q <= mem_word(mem_address_o);
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_mem(input logic wr, input logic [5:0] addr, input logic [31:0] data);
        mem_txn_t t;
        t.wr   = wr;
        t.addr = addr;
        t.data = data;
        exp_mem.push_back(t);
    endtask

    // Starts at posedge+1; returns at posedge+1 after the access completes.
    task automatic do_access(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                             input logic [7:0] exp, output int cycles);
        write_i     = wr;
        read_i      = !wr;
        address_i   = a;
        writedata_i = wd;
        if (!wr) exp_rd.push_back(exp);
        cycles = 0;
        @(negedge clk);
        while (busywait_o && cycles < 50) begin
            cycles++;
            @(negedge clk);
        end
        if (busywait_o) begin
            tests++;
            fails++;
            $display("FAIL access_timeout: addr 0x%0h still busy after %0d cycles", a, cycles);
        end
        @(posedge clk);
        #1;
        read_i  = 1'b0;
        write_i = 1'b0;
    endtask

    task automatic check_stats(input string name, input int exp_hit, input int exp_miss);
        check({name, "_hit"}, {16'h0, hit_count_o}, Stats ? exp_hit : 0);
        check({name, "_miss"}, {16'h0, miss_count_o}, Stats ? exp_miss : 0);
    endtask

    // Monitor: load completions, memory request starts, and memory-side idle values.
    initial begin
        logic     prev_rd = 1'b0;
        logic     prev_wr = 1'b0;
        logic [7:0] e;
        mem_txn_t t;
        forever begin
            @(negedge clk);
            if (!reset_i) begin
                if (read_i && !write_i && !busywait_o) begin
                    tests++;
                    if (exp_rd.size() == 0) begin
                        fails++;
                        $display("FAIL rd_unexpected: got 0x%0h with no load pending", readdata_o);
                    end else begin
                        e = exp_rd.pop_front();
                        if (readdata_o !== e) begin
                            fails++;
                            $display("FAIL readdata: got 0x%0h expected 0x%0h", readdata_o, e);
                        end
                    end
                end
                if ((mem_read_o && !prev_rd) || (mem_write_o && !prev_wr)) begin
                    tests++;
                    if (exp_mem.size() == 0) begin
                        fails++;
                        $display("FAIL mem_unexpected: rd=%0b wr=%0b addr 0x%0h", mem_read_o,
                                 mem_write_o, mem_address_o);
                    end else begin
                        t = exp_mem.pop_front();
                        if (mem_write_o !== t.wr || mem_read_o !== !t.wr || mem_address_o !== t.addr
                            || (t.wr && mem_writedata_o !== t.data)) begin
                            fails++;
                            $display("FAIL mem_req: got wr=%0b addr 0x%0h data 0x%0h expected wr=%0b addr 0x%0h data 0x%0h",
                                     mem_write_o, mem_address_o, mem_writedata_o, t.wr, t.addr, t.data);
                        end
                    end
                end
                tests++;
                if ((mem_read_o && mem_write_o) || (!mem_read_o && !mem_write_o &&
                    (mem_address_o != 6'h0 || mem_writedata_o != 32'h0))) begin
                    fails++;
                    $display("FAIL mem_idle: rd=%0b wr=%0b addr 0x%0h data 0x%0h expected no overlap and zero when idle",
                             mem_read_o, mem_write_o, mem_address_o, mem_writedata_o);
                end
            end
            prev_rd = mem_read_o;
            prev_wr = mem_write_o;
        end
    end

    initial begin
        int cyc;
        int n_hits;
        reset_i     = 1'b1;
        read_i      = 1'b0;
        write_i     = 1'b0;
        address_i   = 8'h00;
        writedata_i = 8'h00;
        repeat (3) @(posedge clk);
        read_i    = 1'b1;
        address_i = 8'h24;
        #1;
        check("busy_in_reset", {31'h0, busywait_o}, 0);
        read_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        check("rst_mem_read", {31'h0, mem_read_o}, 0);
        check("rst_mem_write", {31'h0, mem_write_o}, 0);
        check("rst_mem_addr", {26'h0, mem_address_o}, 0);
        check("rst_mem_wdata", mem_writedata_o, 0);
        check("rst_busy", {31'h0, busywait_o}, 0);
        check("rst_readdata", {24'h0, readdata_o}, 0);
        check_stats("rst", 0, 0);
        @(posedge clk);
        #1;

        // Clean read miss, 5 busy memory cycles
        mem_lat = 5;
        push_mem(1'b0, 6'h09, 32'h0);
        do_access(1'b0, 8'h24, 8'h00, 8'hAA, cyc);
        check("clean_miss_latency", cyc, 8);
        check_stats("after_miss", 0, 1);

        do_access(1'b0, 8'h27, 8'h00, 8'hDD, cyc);
        check("read_hit_latency", cyc, 0);
        check_stats("after_hit", 1, 1);

        do_access(1'b1, 8'h25, 8'h55, 8'h00, cyc);
        check("write_hit_latency", cyc, 0);
        check_stats("after_whit", 2, 1);

        // Dirty miss: write-back of the modified block, then fetch
        mem_lat = 2;
        push_mem(1'b1, 6'h09, 32'hDDCC55AA);
        push_mem(1'b0, 6'h29, 32'h0);
        do_access(1'b0, 8'hA5, 8'h00, 8'h33, cyc);
        check("dirty_miss_latency", cyc, 8);
        check_stats("after_dmiss", 2, 2);
        do_access(1'b0, 8'hA6, 8'h00, 8'h22, cyc);
        check_stats("after_hit2", 3, 2);

        // Write-allocate miss on an invalid line
        mem_lat = 1;
        push_mem(1'b0, 6'h10, 32'h0);
        do_access(1'b1, 8'h40, 8'h77, 8'h00, cyc);
        check("write_miss_latency", cyc, 4);
        do_access(1'b0, 8'h40, 8'h00, 8'h77, cyc);
        do_access(1'b0, 8'h43, 8'h00, 8'hA1, cyc);
        check_stats("after_wmiss", 5, 3);

        push_mem(1'b1, 6'h10, 32'hA1B2C377);
        push_mem(1'b0, 6'h00, 32'h0);
        do_access(1'b0, 8'h00, 8'h00, 8'h80, cyc);
        check("evict_latency", cyc, 6);
        check_stats("after_evict", 5, 4);

        // Reset in the middle of a fetch
        mem_lat = 20;
        push_mem(1'b0, 6'h18, 32'h0);
        read_i    = 1'b1;
        address_i = 8'h60;
        cyc = 0;
        @(negedge clk);
        while (!mem_read_o && cyc < 10) begin
            cyc++;
            @(negedge clk);
        end
        check("fetch_started", {31'h0, mem_read_o}, 1);
        repeat (2) @(negedge clk);
        reset_i = 1'b1;
        #1;
        check("abort_mem_read", {31'h0, mem_read_o}, 0);
        check("abort_busy", {31'h0, busywait_o}, 0);
        check("abort_readdata", {24'h0, readdata_o}, 0);
        read_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;
        @(posedge clk);
        #1;
        check_stats("after_abort", 0, 0);

        mem_lat = 1;
        push_mem(1'b0, 6'h00, 32'h0);
        do_access(1'b0, 8'h00, 8'h00, 8'h80, cyc);
        check("remiss_latency", cyc, 4);
        check_stats("after_remiss", 0, 1);

        // Long hit run for counter saturation
        n_hits = Stats ? 65534 : 20;
        for (int i = 0; i < n_hits; i++) begin
            do_access(1'b0, 8'h00, 8'h00, 8'h80, cyc);
        end
        check_stats("near_sat", 16'hFFFE, 1);
        for (int i = 0; i < 5; i++) begin
            do_access(1'b0, 8'h00, 8'h00, 8'h80, cyc);
        end
        check_stats("saturated", 16'hFFFF, 1);

        repeat (3) @(posedge clk);
        check("rd_queue_empty", exp_rd.size(), 0);
        check("mem_queue_empty", exp_mem.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back data cache between the CPU's load/store path and the 32-bit-block data memory. It returns READDATA, the memory-side input of the register-file writeback select, and raises BUSYWAIT to stall the CPU on misses. Geometry is fixed: 8-bit byte address, 8 blocks × 4 bytes, with tag[7:5], index[4:2] and offset[1:0].

## Interface
- No parameters; geometry is fixed.
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-high reset.
- READ  in  1  CPU load request; held until BUSYWAIT is low.
- WRITE  in  1  CPU store request; held until BUSYWAIT is low. Wins if asserted together with READ.
- ADDRESS  in  8  CPU byte address.
- WRITEDATA  in  8  store data.
- READDATA  out  8  load data; valid when READ=1 and BUSYWAIT=0.
- BUSYWAIT  out  1  stall request to the CPU.
- MEM_READ  out  1  block fetch request.
- MEM_WRITE  out  1  block write-back request.
- MEM_ADDRESS  out  6  block address {tag,index}.
- MEM_WRITEDATA  out  32  victim block; byte0 = [7:0].
- MEM_READDATA  in  32  fetched block; byte0 = [7:0].
- MEM_BUSYWAIT  in  1  memory busy; low means the request completes at this posedge.
- HIT_COUNT  out  16  statistics output; see Configuration.
- MISS_COUNT  out  16  statistics output; see Configuration.

## Operation
- Per-block storage: valid, dirty, tag[2:0], data[31:0].
- A hit is `valid[index] && tag[index]==ADDRESS[7:5]`, evaluated combinationally.
- FSM states and transitions:
  - IDLE: on READ|WRITE with a miss, go to WRITEBACK if dirty[index], otherwise to FETCH.
  - WRITEBACK:
    - MEM_WRITE=1.
    - MEM_ADDRESS={stored tag,index}.
    - MEM_WRITEDATA=stored block.
    - Exit to FETCH on a posedge with MEM_BUSYWAIT=0.
  - FETCH:
    - MEM_READ=1.
    - MEM_ADDRESS=ADDRESS[7:2].
    - Exit to UPDATE on a posedge with MEM_BUSYWAIT=0.
  - UPDATE: one cycle. At its posedge, capture MEM_READDATA into the block and set valid=1, dirty=0, tag=ADDRESS[7:5]. Then go to IDLE.
- BUSYWAIT = (READ|WRITE) && (state!=IDLE || !hit). It is forced to 0 while RESET=1.
- Read hit: READDATA = data[index] byte selected by ADDRESS[1:0], combinational. No state change.
- Write hit: at the posedge, write WRITEDATA into the selected byte and set dirty=1. BUSYWAIT stays low, so the store completes in one cycle.
- Miss: after UPDATE the still-held request hits in IDLE and completes as above. Write misses are write-allocate.
- MEM_READ and MEM_WRITE are never high together. Outside WRITEBACK/FETCH, both are 0, and MEM_ADDRESS and MEM_WRITEDATA are 0.

## Timing
- Reset values:
  - All valid and dirty bits 0.
  - State IDLE.
  - MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
  - BUSYWAIT=0, READDATA=0.
  - Counters 0.
- Reset mid-operation aborts immediately. The memory request drops in the same cycle, all lines are invalidated, and dirty data is discarded.
- Hit latency is 0 cycles (combinational).
- Clean-miss latency: 1 (IDLE to FETCH) + N memory cycles + 1 (UPDATE) + the hit cycle.
- Dirty-miss latency adds the write-back duration.
- If READ/WRITE is dropped mid-miss (protocol violation), the FSM still completes the fill.
- Data storage is not reset beyond the valid bits. READDATA on an invalid line is don't-care.

## Configuration
- CACHE_STATS_EN defined:
  - HIT_COUNT increments once per access that hits on its first IDLE cycle.
  - MISS_COUNT increments once per IDLE-to-WRITEBACK or IDLE-to-FETCH transition.
  - The hit that completes a refilled access is not counted; a refill_done flag is set in UPDATE and cleared on the next IDLE cycle.
  - Both counters are 16-bit and saturate at 0xFFFF.
- CACHE_STATS_EN undefined: HIT_COUNT and MISS_COUNT are tied to 0 and no counter logic is built.

## Test plan
- Reset, then READ ADDRESS=0x24 with memory returning 0xDDCCBBAA after 5 busy cycles. Required response:
  - BUSYWAIT is high until the fill.
  - MEM_READ is high with MEM_ADDRESS=0x09.
  - READDATA=0xAA once BUSYWAIT is low.
  - Stats: MISS=1, HIT=0.
- Following READ 0x27: READDATA=0xDD in the same cycle, BUSYWAIT never high, HIT=1.
- WRITE 0x25=0x55 (hit), then READ 0xA5 (same index, new tag). Required response:
  - MEM_WRITE with MEM_ADDRESS=0x09 and MEM_WRITEDATA=0xDDCC55AA.
  - Then MEM_READ with MEM_ADDRESS=0x29.
  - MEM_READ and MEM_WRITE never overlap.
- WRITE miss 0x40=0x77 on a clean invalid line. Required response:
  - The block is fetched and byte 0 is then overwritten; later READ 0x40 returns 0x77.
  - Evicting this block writes it back with byte0=0x77.
- RESET pulsed during FETCH: MEM_READ drops immediately, BUSYWAIT=0, and the next READ to the same address misses again.
- Run more than 65535 hits with CACHE_STATS_EN: HIT_COUNT saturates at 0xFFFF. Without the macro, both counters read 0 throughout.
